// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths, ALU codes, opcodes and pipeline state type.
// Rev     : 1.0
// ============================================================================
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    localparam logic [3:0] ALU_NOR = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;

    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_OP26  = 6'd26;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use hazard check between EX load and ID sources.
// Rev     : 1.0
// ============================================================================
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_data_read_ex,
    input  logic [REG_W-1:0] i_rt_ex,
    input  logic [REG_W-1:0] i_rs_id,
    input  logic [REG_W-1:0] i_rt_id,
    output logic             o_hit
);

    // $zero never carries a real dependency
    assign o_hit = i_data_read_ex & (i_rt_ex != '0) &
                   ((i_rt_ex == i_rs_id) | (i_rt_ex == i_rt_id));

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with load-use bubble insertion and stall count.
// Rev     : 1.0
// ============================================================================
import cpu_pkg::*;

module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W_DEF,
    parameter int REG_W  = cpu_pkg::REG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_ID,
    input  logic              Write_regnum_Src_sel_line_ID,
    input  logic              ALU_Src_sel_line_ID,
    input  logic              data_write_ID,
    input  logic              write_Data_Src_mux_ID,
    input  logic              Set_Less_than_inst_ID,
    input  logic              data_read_ID,
    input  logic [3:0]        ALU_ctrl_ID,
    input  logic              flush,
    input  logic [DATA_W-1:0] Rs_data_ID,
    input  logic [DATA_W-1:0] Rt_data_ID,
    input  logic [DATA_W-1:0] Imm_ext_ID,
    input  logic [REG_W-1:0]  Rs_ID,
    input  logic [REG_W-1:0]  Rt_ID,
    input  logic [REG_W-1:0]  Rd_ID,
    output logic              reg_write_EX,
    output logic              Write_regnum_Src_sel_line_EX,
    output logic              ALU_Src_sel_line_EX,
    output logic              data_write_EX,
    output logic              write_Data_Src_mux_EX,
    output logic              Set_Less_than_inst_EX,
    output logic              data_read_EX,
    output logic [3:0]        ALU_ctrl_EX,
    output logic [DATA_W-1:0] Rs_data_EX,
    output logic [DATA_W-1:0] Rt_data_EX,
    output logic [DATA_W-1:0] Imm_ext_EX,
    output logic [REG_W-1:0]  Rs_EX,
    output logic [REG_W-1:0]  Rt_EX,
    output logic [REG_W-1:0]  Rd_EX,
    output logic [REG_W-1:0]  Write_regnum_EX,
    output logic              stall,
    output logic              flush_IF,
    output logic [15:0]       stall_count
);

    localparam int CTRL_W = 11;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_hit;
    logic                w_stall;
    logic [CTRL_W-1:0]   w_ctrl_id;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_rs_data;
    logic [DATA_W-1:0]   r_rt_data;
    logic [DATA_W-1:0]   r_imm;
    logic [REG_W-1:0]    r_rs;
    logic [REG_W-1:0]    r_rt;
    logic [REG_W-1:0]    r_rd;
    logic [15:0]         r_stall_count;

    assign w_ctrl_id = {reg_write_ID, Write_regnum_Src_sel_line_ID, ALU_Src_sel_line_ID,
                        data_write_ID, write_Data_Src_mux_ID, Set_Less_than_inst_ID,
                        data_read_ID, ALU_ctrl_ID};

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .i_data_read_ex (data_read_EX),
        .i_rt_ex        (r_rt),
        .i_rs_id        (Rs_ID),
        .i_rt_id        (Rt_ID),
        .o_hit          (w_hit)
    );

    assign w_stall = w_hit & (r_state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_stall) w_state_nxt = BUBBLE;
            BUBBLE:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Data and register numbers always advance; the held ID instruction
    // is simply recaptured on the edge after the bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
        end else begin
            r_ctrl    <= w_stall ? '0 : w_ctrl_id;
            r_rs_data <= Rs_data_ID;
            r_rt_data <= Rt_data_ID;
            r_imm     <= Imm_ext_ID;
            r_rs      <= Rs_ID;
            r_rt      <= Rt_ID;
            r_rd      <= Rd_ID;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign {reg_write_EX, Write_regnum_Src_sel_line_EX, ALU_Src_sel_line_EX,
            data_write_EX, write_Data_Src_mux_EX, Set_Less_than_inst_EX,
            data_read_EX, ALU_ctrl_EX} = r_ctrl;

    assign Rs_data_EX      = r_rs_data;
    assign Rt_data_EX      = r_rt_data;
    assign Imm_ext_EX      = r_imm;
    assign Rs_EX           = r_rs;
    assign Rt_EX           = r_rt;
    assign Rd_EX           = r_rd;
    assign Write_regnum_EX = Write_regnum_Src_sel_line_EX ? r_rd : r_rt;
    assign stall           = w_stall;
    assign flush_IF        = flush & ~w_stall;
    assign stall_count     = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Directed plus random checks of id_ex_stage against a pipeline model.
// Rev     : 1.0
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic [10:0] ctl;
    logic        flush;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;

    logic        o_rw, o_ws, o_as, o_dw, o_wd, o_slt, o_dr;
    logic [3:0]  o_alu;
    logic [31:0] o_rsd, o_rtd, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd, o_wr;
    logic        o_stall, o_flush_if;
    logic [15:0] o_cnt;

    int vectors;
    int miscompares;

    // Model of what EX should hold: the previous ID instruction, with its
    // controls cleared whenever that edge was a load-use bubble.
    logic [10:0] m_ctl;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    bit          m_last_stalled;
    int          m_cnt;

    id_ex_stage dut (
        .clk                          (clk),
        .reset                        (reset),
        .reg_write_ID                 (ctl[10]),
        .Write_regnum_Src_sel_line_ID (ctl[9]),
        .ALU_Src_sel_line_ID          (ctl[8]),
        .data_write_ID                (ctl[7]),
        .write_Data_Src_mux_ID        (ctl[6]),
        .Set_Less_than_inst_ID        (ctl[5]),
        .data_read_ID                 (ctl[4]),
        .ALU_ctrl_ID                  (ctl[3:0]),
        .flush                        (flush),
        .Rs_data_ID                   (rs_d),
        .Rt_data_ID                   (rt_d),
        .Imm_ext_ID                   (imm),
        .Rs_ID                        (rs),
        .Rt_ID                        (rt),
        .Rd_ID                        (rd),
        .reg_write_EX                 (o_rw),
        .Write_regnum_Src_sel_line_EX (o_ws),
        .ALU_Src_sel_line_EX          (o_as),
        .data_write_EX                (o_dw),
        .write_Data_Src_mux_EX        (o_wd),
        .Set_Less_than_inst_EX        (o_slt),
        .data_read_EX                 (o_dr),
        .ALU_ctrl_EX                  (o_alu),
        .Rs_data_EX                   (o_rsd),
        .Rt_data_EX                   (o_rtd),
        .Imm_ext_EX                   (o_imm),
        .Rs_EX                        (o_rs),
        .Rt_EX                        (o_rt),
        .Rd_EX                        (o_rd),
        .Write_regnum_EX              (o_wr),
        .stall                        (o_stall),
        .flush_IF                     (o_flush_if),
        .stall_count                  (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_stall();
        if (m_last_stalled) return 1'b0;
        return (m_ctl[4] === 1'b1) && (m_rt != 5'd0) && ((m_rt == rs) || (m_rt == rt));
    endfunction

    task automatic model_reset();
        m_ctl = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_last_stalled = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit s;
        s = m_stall();
        m_ctl = s ? 11'd0 : ctl;
        m_rsd = rs_d; m_rtd = rt_d; m_imm = imm;
        m_rs = rs; m_rt = rt; m_rd = rd;
        m_last_stalled = s;
        if (s && m_cnt < 65535) m_cnt++;
    endtask

    task automatic check_all();
        logic [4:0] exp_wr;
        exp_wr = m_ctl[9] ? m_rd : m_rt;
        chk("ctl_EX", {o_rw, o_ws, o_as, o_dw, o_wd, o_slt, o_dr, o_alu}, m_ctl);
        chk("data_EX", {o_rsd, o_rtd, o_imm}, {m_rsd, m_rtd, m_imm});
        chk("regs_EX", {o_rs, o_rt, o_rd}, {m_rs, m_rt, m_rd});
        chk("Write_regnum_EX", o_wr, exp_wr);
        chk("stall", o_stall, m_stall());
        chk("flush_IF", o_flush_if, flush & ~m_stall());
        chk("stall_count", o_cnt, m_cnt[15:0]);
    endtask

    task automatic step(input bit do_chk);
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic [10:0] c, input logic f, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [31:0] sd);
        ctl = c; flush = f; rs = s; rt = t; rd = d;
        rs_d = sd; rt_d = sd ^ 32'hA5A5_0000; imm = {27'd0, d} + 32'h100;
    endtask

    localparam logic [10:0] C_ADD  = 11'b1100000_0001;
    localparam logic [10:0] C_LOAD = 11'b1010101_0001;
    localparam logic [10:0] C_JR   = 11'b0000000_0000;

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        drive(C_ADD, 1'b1, 5'd1, 5'd2, 5'd3, 32'h1);
        model_reset();
        #1;
        chk("reset_flush_IF", o_flush_if, 1'b1);
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // ADD: Rs_data 5, Rt 4, Rd 9
        drive(C_ADD, 1'b0, 5'd1, 5'd4, 5'd9, 32'h5);
        step(1);
        #1;
        chk("add_alu", o_alu, 4'b0001);
        chk("add_rsdata", o_rsd, 32'h5);
        chk("add_wr", o_wr, 5'd9);

        // load Rt 8 followed by a dependent ADD
        drive(C_LOAD, 1'b0, 5'd3, 5'd8, 5'd0, 32'h77);
        step(1);
        drive(C_ADD, 1'b0, 5'd8, 5'd4, 5'd10, 32'h12);
        #1;
        chk("lu_stall", o_stall, 1'b1);
        step(1);
        #1;
        chk("lu_bubble_ctl", {o_rw, o_ws, o_as, o_dw, o_wd, o_slt, o_dr, o_alu}, 11'd0);
        chk("lu_count", o_cnt, 16'd1);
        chk("lu_stall_off", o_stall, 1'b0);
        step(1);
        #1;
        chk("lu_add_in_ex", {o_rw, o_ws, o_as, o_dw, o_wd, o_slt, o_dr, o_alu}, C_ADD);
        chk("lu_add_stall", o_stall, 1'b0);

        // load into $zero never stalls
        drive(C_LOAD, 1'b0, 5'd3, 5'd0, 5'd0, 32'h9);
        step(1);
        drive(C_ADD, 1'b0, 5'd0, 5'd0, 5'd11, 32'h3);
        #1;
        chk("zero_stall", o_stall, 1'b0);
        step(1);
        #1;
        chk("zero_count", o_cnt, 16'd1);

        // jr depending on a load: held, then flushed
        drive(C_LOAD, 1'b0, 5'd3, 5'd8, 5'd0, 32'h44);
        step(1);
        drive(C_JR, 1'b1, 5'd8, 5'd0, 5'd0, 32'h0);
        #1;
        chk("jr_stall", o_stall, 1'b1);
        chk("jr_flush_held", o_flush_if, 1'b0);
        step(1);
        #1;
        chk("jr_flush_go", o_flush_if, 1'b1);
        step(1);

        // async reset in the middle of a stall
        drive(C_LOAD, 1'b0, 5'd3, 5'd6, 5'd0, 32'h55);
        step(1);
        drive(C_ADD, 1'b0, 5'd6, 5'd2, 5'd12, 32'h66);
        #1;
        chk("pre_reset_stall", o_stall, 1'b1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_stall", o_stall, 1'b0);
        chk("async_rst_cnt", o_cnt, 16'd0);
        chk("async_rst_rsd", o_rsd, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        #1;
        chk("post_rst_capture", {o_rw, o_ws, o_as, o_dw, o_wd, o_slt, o_dr, o_alu}, C_ADD);

        // X control passes through when not bubbled
        drive(C_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 32'h7);
        ctl[8] = 1'bx;
        step(1);
        step(1);

        // random traffic over a small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            ctl   = 11'($urandom);
            flush = 1'($urandom);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            rd    = 5'($urandom);
            rs_d  = $urandom;
            rt_d  = $urandom;
            imm   = $urandom;
            step(1);
        end

        // drive back-to-back load-use pairs until the counter must pin
        drive(C_LOAD, 1'b0, 5'd8, 5'd8, 5'd0, 32'h1);
        step(1);
        for (int i = 0; i < 2 * 65537; i++) step(1'b0);
        step(1);
        #1;
        chk("sat_count", o_cnt, 16'hFFFF);
        for (int i = 0; i < 4; i++) step(1);
        #1;
        chk("sat_hold", o_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
